// File: rtl/serial_subtractor_nbit.sv
// rtl/serial_subtractor_nbit.sv - bit-serial unsigned subtractor (a - b - borrow_in), LSB first
// One full-subtractor cell plus a borrow flop; result valid with the one-cycle done pulse.
module serial_subtractor_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 borrow_in,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] diff,
  output logic                 underflow
);

  localparam int CW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_next;
  logic [BIT_WIDTH-1:0] a_r, b_r;
  logic                 bor;
  logic [CW-1:0]        cnt;
  logic                 d, bor_next, last;

  assign d        = a_r[0] ^ b_r[0] ^ bor;
  assign bor_next = (~a_r[0] & b_r[0]) | (~(a_r[0] ^ b_r[0]) & bor);
  assign last     = (cnt == CW'(BIT_WIDTH - 1));

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The minuend register doubles as the working difference: each difference
  // bit enters at the MSB as the consumed minuend bit leaves at the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      bor       <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
            bor <= borrow_in;
            cnt <= '0;
          end
        end
        SHIFT: begin
          a_r <= {d, a_r[BIT_WIDTH-1:1]};
          b_r <= {1'b0, b_r[BIT_WIDTH-1:1]};
          bor <= bor_next;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            diff      <= {d, a_r[BIT_WIDTH-1:1]};
            underflow <= bor_next;
          end
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst && state == IDLE && start) begin
      assert (!$isunknown(a)) else $error("Input a is not a digital logic value");
      assert (!$isunknown(b)) else $error("Input b is not a digital logic value");
      assert (!$isunknown(borrow_in)) else $error("Input borrow_in is not a digital logic value");
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// tb/tb_serial_subtractor_nbit.sv - randomized self-checking bench for serial_subtractor_nbit
// Cycle-level arithmetic model compared every cycle, plus literal result checks.
module tb_serial_subtractor_nbit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         borrow_in;
  logic         busy, done, underflow;
  logic [W-1:0] diff;

  serial_subtractor_nbit #(.BIT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ph=0 idle, 1..W operation in flight, W+1 result cycle.
  int           ph = 0;
  int           cyc = 0;
  logic [W-1:0] m_diff = '0, p_diff = '0;
  logic         m_uf = 1'b0, p_uf = 1'b0;
  int           sa, sb, sbi;
  int           m_accepts = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; m_diff = '0; m_uf = 1'b0;
    end else begin
      cyc++;
      if (ph == 0) begin
        if (start === 1'b1) begin
          sa = int'(a); sb = int'(b); sbi = int'(borrow_in);
          p_diff = W'(sa - sb - sbi);
          p_uf   = (sa < sb + sbi);
          m_accepts++;
          ph = 1;
        end
      end else if (ph == W + 1) begin
        ph = 0;
      end else begin
        ph++;
        if (ph == W + 1) begin
          m_diff = p_diff;
          m_uf   = p_uf;
        end
      end
    end
  end

  logic chk_en = 1'b0;
  logic prev_busy = 1'b0;
  int   n_done = 0;
  int   ncyc = 0;
  int   dut_acc[$];

  always @(negedge clk) begin
    ncyc++;
    if (chk_en) begin
      chk("busy", busy, (ph >= 1 && ph <= W));
      chk("done", done, (ph == W + 1));
      chk("diff", diff, m_diff);
      chk("underflow", underflow, m_uf);
      if (done) n_done++;
      if (busy && !prev_busy) dut_acc.push_back(ncyc);
      prev_busy = busy;
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbi,
                        input logic [W-1:0] ed, input logic eu, input bit scramble, input string name);
    int k;
    @(negedge clk);
    a = ta; b = tb_v; borrow_in = tbi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin a = '0; b = '0; borrow_in = ~tbi; end
    k = 1;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_latency"}, k, W + 1);
    chk({name, "_diff"}, diff, ed);
    chk({name, "_underflow"}, underflow, eu);
    @(negedge clk);
  endtask

  initial begin
    int base, nd0, k;
    rst = 1'b1; start = 1'b1; a = 4'hF; b = '0; borrow_in = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_accepts", dut_acc.size(), 0);
    start = 1'b0; rst = 1'b0;

    run_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b0, "basic");
    run_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1, "uflow");
    run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, "bin_zero");
    run_op(4'hF, 4'd0, 1'b1, 4'hE, 1'b0, 1'b1, "bin_full");

    // start held high
    @(negedge clk);
    a = 4'd9; b = 4'd3; borrow_in = 1'b0;
    base = dut_acc.size(); nd0 = n_done;
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    k = 0;
    while ((busy || done) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("held_drain", (busy || done), 0);
    chk("held_accepts", dut_acc.size() - base, 4);
    for (int i = base + 1; i < dut_acc.size(); i++)
      chk("held_spacing", dut_acc[i] - dut_acc[i-1], W + 2);
    chk("held_dones", n_done - nd0, 4);
    chk("held_diff", diff, 4'h6);

    // reset during SHIFT
    @(negedge clk);
    a = 4'd5; b = 4'd1; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_diff", diff, 0);
    chk("midrst_underflow", underflow, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    nd0 = n_done;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", n_done - nd0, 0);
    run_op(4'd5, 4'd1, 1'b0, 4'h4, 1'b0, 1'b0, "after_rst");

    // randomized operations, inputs wiggled while running
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom); start = 1'b1;
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      k = 0;
      while (!done && k < 30) begin
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        @(negedge clk);
        k++;
      end
      chk("rand_done_seen", done, 1);
      start = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (W + 3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
